// File: rtl/otp_stream_decrypt.sv
// rtl/otp_stream_decrypt.sv - streaming one-time-pad decryptor (XOR with cyclic key stream)
// Optional feature macro: OTP_STRICT_EN (true one-time key use, no wrap)
module otp_stream_decrypt #(
  parameter int KEY_BITS = 64,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_load,
  input  logic [DATA_W-1:0]   ct_data,
  input  logic                ct_valid,
  output logic                ct_ready,
  output logic [DATA_W-1:0]   pt_data,
  output logic                pt_valid,
  input  logic                pt_ready,
  output logic                key_loaded,
  output logic                key_exhausted
);

  // Pointer wide enough to index any key bit; at least one bit for KEY_BITS == 1.
  localparam int PTR_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  // Pointer advance per beat, pre-reduced so the update needs a single conditional subtract.
  localparam int STEP  = DATA_W % KEY_BITS;
`ifdef OTP_STRICT_EN
  // Holds 0..KEY_BITS inclusive.
  localparam int BU_W  = $clog2(KEY_BITS + 1);
`endif

  typedef enum logic [1:0] {
    NOKEY     = 2'd0,
    ACTIVE    = 2'd1,
    EXHAUSTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0]   pt_data_q, pt_data_d;
  logic                pt_valid_q, pt_valid_d;
  logic                key_loaded_q, key_loaded_d;
  logic                key_exhausted_q, key_exhausted_d;
`ifdef OTP_STRICT_EN
  logic [BU_W-1:0]     bits_used_q, bits_used_d;
`endif

  logic [DATA_W-1:0]   keystream;
  logic                fits;
  logic                accept;

  // Key stream for the current beat: DATA_W bits starting at ptr, wrapping modulo KEY_BITS.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    keystream = '0;
    idx       = 0;
    idx_w     = '0;
    for (int j = 0; j < DATA_W; j++) begin
      idx          = (int'(ptr_q) + j) % KEY_BITS;
      idx_w        = PTR_W'(idx);
      keystream[j] = key_q[idx_w];
    end
  end

  // Handshake: load has priority, output register must be free, strict mode needs a whole word of key left.
  always_comb begin
`ifdef OTP_STRICT_EN
    fits = (int'(bits_used_q) + DATA_W) <= KEY_BITS;
`else
    fits = 1'b1;
`endif
    ct_ready = (state_q == ACTIVE) && !key_load && (!pt_valid_q || pt_ready) && fits;
    accept   = ct_valid && ct_ready;
  end

  // Next-state, key/pointer bookkeeping and output register update.
  always_comb begin
    int nxt;
    state_d     = state_q;
    key_d       = key_q;
    ptr_d       = ptr_q;
    pt_data_d   = pt_data_q;
    pt_valid_d  = pt_valid_q;
`ifdef OTP_STRICT_EN
    bits_used_d = bits_used_q;
`endif
    nxt         = 0;

    case (state_q)
      NOKEY:     if (key_load) state_d = ACTIVE;
      ACTIVE: begin
        if (key_load) state_d = ACTIVE;
`ifdef OTP_STRICT_EN
        else if (!fits) state_d = EXHAUSTED;
`endif
      end
      EXHAUSTED: if (key_load) state_d = ACTIVE;
      default:   state_d = NOKEY;
    endcase

    if (key_load) begin
      key_d       = key_in;
      ptr_d       = '0;
`ifdef OTP_STRICT_EN
      bits_used_d = '0;
`endif
    end else if (accept) begin
      nxt = int'(ptr_q) + STEP;
      if (nxt >= KEY_BITS) nxt = nxt - KEY_BITS;
      ptr_d = PTR_W'(nxt);
`ifdef OTP_STRICT_EN
      bits_used_d = BU_W'(int'(bits_used_q) + DATA_W);
`endif
    end

    // A pending word drains independently of key_load.
    if (accept) begin
      pt_data_d  = ct_data ^ keystream;
      pt_valid_d = 1'b1;
    end else if (pt_ready) begin
      pt_valid_d = 1'b0;
    end

    key_loaded_d    = (state_d != NOKEY);
    key_exhausted_d = (state_d == EXHAUSTED);
  end

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= NOKEY;
      key_q           <= '0;
      ptr_q           <= '0;
      pt_data_q       <= '0;
      pt_valid_q      <= 1'b0;
      key_loaded_q    <= 1'b0;
      key_exhausted_q <= 1'b0;
`ifdef OTP_STRICT_EN
      bits_used_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      key_q           <= key_d;
      ptr_q           <= ptr_d;
      pt_data_q       <= pt_data_d;
      pt_valid_q      <= pt_valid_d;
      key_loaded_q    <= key_loaded_d;
      key_exhausted_q <= key_exhausted_d;
`ifdef OTP_STRICT_EN
      bits_used_q     <= bits_used_d;
`endif
    end
  end

  assign pt_data       = pt_data_q;
  assign pt_valid      = pt_valid_q;
  assign key_loaded    = key_loaded_q;
  assign key_exhausted = key_exhausted_q;

endmodule
